conv33_ctrl: RTL and testbench
==============================

Name: conv33_ctrl

Overview:
Sequencer that streams a row-major image from a 3-row-wide pixel memory into the 3x3 sliding-window convolution unit. It issues column reads for each row triplet and drives the convolution unit's window-shift enable. It tracks window fill per row and presents each valid convolution result with its (row, col) coordinate on a valid/ready output handshake. Sits between the feature-map buffer and the downstream result writer.

Parameters:
IMG_W, 32, image width in pixels (>=3)
IMG_H, 32, image height in pixels (>=3)
RW, $clog2(IMG_H), row index width (derived)
CW, $clog2(IMG_W), column index width (derived)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
start  in  1  one-cycle pulse; begins a frame when idle
busy  out  1  high from start acceptance until done
done  out  1  one-cycle pulse after the last result handshake
rd_en  out  1  memory read strobe
rd_row  out  RW  top row of the triplet; memory returns rows rd_row, +1, +2 on in1..in3
rd_col  out  CW  column to read
conv_en  out  1  window shift enable to the convolution unit
out_valid  out  1  convValue holds a valid result
out_ready  in  1  downstream accepts the result
out_row  out  RW  result row (top-left of window)
out_col  out  CW  result column (top-left of window)
stall_cnt  out  16  stall counter (optional feature)

Behaviour:
- Reset (rst=0, async): state IDLE. All outputs 0; all counters 0.
- States: IDLE -> RUN on start. RUN -> DRAIN after the last read issues. DRAIN -> IDLE after the final result handshake, with done=1 for that one cycle.
- start ignored while busy. busy=1 in RUN/DRAIN.
- Memory contract: read data valid the cycle after rd_en and held stable while rd_en=0.
- advance = !(out_valid && !out_ready).
- RUN: each cycle with advance=1: rd_en=1 for (rd_row, rd_col), then rd_col++.
  - At rd_col==IMG_W-1: rd_col->0, rd_row++.
  - Last issue at (IMG_H-3, IMG_W-1), then go to DRAIN.
- pending flag: set by rd_en; cleared when the data is consumed.
- conv_en = pending && advance. Data never shifts into the window while a result is stalled.
- Fill counter per row: reset to 0 when the first column of a new row is consumed; saturates at 3.
- On a conv_en edge where the consumed column c>=2:
  - next cycle out_valid=1, out_row = row of that data, out_col = c-2.
  - Otherwise out_valid clears on handshake.
- Latency: start sampled at edge k -> rd_en in cycles k+1.. -> first conv_en k+2 -> first out_valid k+5.
- Throughput: 1 result/cycle within a row; 2-bubble cycles at each row change.
- Total results: (IMG_H-2)*(IMG_W-2).
- Stall: rd_en, conv_en, counters and out_* all frozen while out_valid && !out_ready.
- Reset mid-frame: immediate return to IDLE; no done pulse.

Optional Feature:
CONV33_STALL_CNT_EN
- Defined: stall_cnt counts cycles with out_valid && !out_ready. Clears to 0 on accepted start. Saturates at 16'hFFFF. Holds after done.
- Undefined: stall_cnt tied to 0 and no counter logic. The port stays present so instantiations are unchanged.

Test Plan:
- IMG_W=5, IMG_H=4, out_ready=1, start at edge 0 -> rd_en in cycles 1-10; out_valid in cycles 5,6,7 (row0, col0-2) and 10,11,12 (row1, col0-2); done in cycle 13; exactly 6 handshakes.
- Same config, out_ready=0 for cycles 5-8 -> out_valid held with (0,0) and no conv_en during 5-8; sequence resumes unchanged; done in cycle 17; stall_cnt=4 with macro, 0 without.
- start pulsed again in cycle 3 while busy -> ignored; results and done timing identical to the first scenario.
- rst=0 in cycle 7 of the first scenario -> all outputs 0 asynchronously; a new start after release runs the full frame from (0,0).
- IMG_W=3, IMG_H=3 -> exactly one result (0,0) in cycle 5; done in cycle 6.
- Random out_ready (50%), IMG_W=8, IMG_H=6 -> 24 results in raster order with no duplicates or skips; convValue matches the reference 3x3 sum for each coordinate.

Source files
------------

// File: rtl/conv33_ctrl.sv
// conv33_ctrl: row-triplet read sequencer and window/result tracker for a 3x3 conv unit.
// Optional stall counter is built when CONV33_STALL_CNT_EN is defined.
module conv33_ctrl #(
  parameter int IMG_W = 32,
  parameter int IMG_H = 32,
  parameter int RW = $clog2(IMG_H),
  parameter int CW = $clog2(IMG_W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          rd_en,
  output logic [RW-1:0] rd_row,
  output logic [CW-1:0] rd_col,
  output logic          conv_en,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [RW-1:0] out_row,
  output logic [CW-1:0] out_col,
  output logic [15:0]   stall_cnt
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [RW-1:0] LAST_ROW  = RW'(IMG_H - 3);
  localparam logic [CW-1:0] LAST_COL  = CW'(IMG_W - 1);
  localparam logic [CW-1:0] LAST_OCOL = CW'(IMG_W - 3);

  state_t        state;
  logic          advance;
  logic          pending;
  logic          col_end;
  logic          last_rd;
  logic          last_hs;
  logic [RW-1:0] pend_row;
  logic [CW-1:0] pend_col;
  logic [1:0]    fill;
  logic [1:0]    fill_nxt;

  assign advance = !(out_valid && !out_ready);
  assign busy    = (state != IDLE);
  assign rd_en   = (state == RUN) && advance;
  assign conv_en = pending && advance;
  assign col_end = (rd_col == LAST_COL);
  assign last_rd = rd_en && col_end && (rd_row == LAST_ROW);
  assign last_hs = out_valid && out_ready &&
                   (out_row == LAST_ROW) &&
                   (out_col == LAST_OCOL);

  // fill counts columns consumed after the first one of the row
  always_comb begin
    fill_nxt = fill;
    if (pend_col == '0)
      fill_nxt = 2'd0;
    else if (fill != 2'd3)
      fill_nxt = fill + 2'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      done      <= 1'b0;
      rd_row    <= '0;
      rd_col    <= '0;
      pending   <= 1'b0;
      pend_row  <= '0;
      pend_col  <= '0;
      fill      <= '0;
      out_valid <= 1'b0;
      out_row   <= '0;
      out_col   <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state  <= RUN;
            rd_row <= '0;
            rd_col <= '0;
            fill   <= '0;
          end
        end
        RUN: begin
          if (last_rd)
            state <= DRAIN;
        end
        DRAIN: begin
          if (last_hs) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (rd_en) begin
        pend_row <= rd_row;
        pend_col <= rd_col;
        if (last_rd) begin
          rd_row <= '0;
          rd_col <= '0;
        end else if (col_end) begin
          rd_col <= '0;
          rd_row <= rd_row + RW'(1);
        end else begin
          rd_col <= rd_col + CW'(1);
        end
      end

      if (rd_en)
        pending <= 1'b1;
      else if (conv_en)
        pending <= 1'b0;

      if (conv_en)
        fill <= fill_nxt;

      if (conv_en && fill_nxt >= 2'd2) begin
        out_valid <= 1'b1;
        out_row   <= pend_row;
        out_col   <= pend_col - CW'(2);
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef CONV33_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stall_cnt <= '0;
    else if (state == IDLE && start)
      stall_cnt <= '0;
    else if (out_valid && !out_ready && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_conv33_ctrl.sv
// tb_conv33_ctrl: directed frames on 5x4 and 3x3 instances,
// random back-pressure with a memory/window model on an 8x6 instance.
module tb_conv33_ctrl;
  localparam int NCYC = 20;
`ifdef CONV33_STALL_CNT_EN
  localparam int SC_ON = 1;
`else
  localparam int SC_ON = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  logic a_start = 1'b0, a_ready = 1'b1;
  logic a_busy, a_done, a_rd_en, a_conv_en, a_out_valid;
  logic [1:0] a_rd_row, a_out_row;
  logic [2:0] a_rd_col, a_out_col;
  logic [15:0] a_stall_cnt;

  logic b_start = 1'b0, b_ready = 1'b1;
  logic b_busy, b_done, b_rd_en, b_conv_en, b_out_valid;
  logic [1:0] b_rd_row, b_out_row;
  logic [1:0] b_rd_col, b_out_col;
  logic [15:0] b_stall_cnt;

  logic c_start = 1'b0, c_ready = 1'b1;
  logic c_busy, c_done, c_rd_en, c_conv_en, c_out_valid;
  logic [2:0] c_rd_row, c_out_row;
  logic [2:0] c_rd_col, c_out_col;
  logic [15:0] c_stall_cnt;

  conv33_ctrl #(.IMG_W(5), .IMG_H(4)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .busy(a_busy), .done(a_done),
    .rd_en(a_rd_en), .rd_row(a_rd_row), .rd_col(a_rd_col),
    .conv_en(a_conv_en), .out_valid(a_out_valid), .out_ready(a_ready),
    .out_row(a_out_row), .out_col(a_out_col), .stall_cnt(a_stall_cnt)
  );

  conv33_ctrl #(.IMG_W(3), .IMG_H(3)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done),
    .rd_en(b_rd_en), .rd_row(b_rd_row), .rd_col(b_rd_col),
    .conv_en(b_conv_en), .out_valid(b_out_valid), .out_ready(b_ready),
    .out_row(b_out_row), .out_col(b_out_col), .stall_cnt(b_stall_cnt)
  );

  conv33_ctrl #(.IMG_W(8), .IMG_H(6)) dut_c (
    .clk(clk), .rst(rst), .start(c_start), .busy(c_busy), .done(c_done),
    .rd_en(c_rd_en), .rd_row(c_rd_row), .rd_col(c_rd_col),
    .conv_en(c_conv_en), .out_valid(c_out_valid), .out_ready(c_ready),
    .out_row(c_out_row), .out_col(c_out_col), .stall_cnt(c_stall_cnt)
  );

  // memory and 3x3 window model for the 8x6 instance
  int img[6][8];
  int mq0, mq1, mq2;
  int w0[3], w1[3], w2[3];

  always @(posedge clk) begin
    if (c_rd_en && int'(c_rd_row) <= 3) begin
      mq0 <= img[int'(c_rd_row)][c_rd_col];
      mq1 <= img[int'(c_rd_row) + 1][c_rd_col];
      mq2 <= img[int'(c_rd_row) + 2][c_rd_col];
    end
    if (c_conv_en) begin
      w0[0] <= w0[1]; w0[1] <= w0[2]; w0[2] <= mq0;
      w1[0] <= w1[1]; w1[1] <= w1[2]; w1[2] <= mq1;
      w2[0] <= w2[1]; w2[1] <= w2[2]; w2[2] <= mq2;
    end
  end

  // per-cycle capture of the 5x4 instance
  logic cv[1:NCYC], cd[1:NCYC], crd[1:NCYC];
  logic cce[1:NCYC], cb[1:NCYC], crdy[1:NCYC];
  logic [1:0] crow[1:NCYC];
  logic [2:0] ccol[1:NCYC];
  logic [15:0] c_sc_end;

  task automatic run_a(input int st_lo, input int st_hi, input int restart_cyc);
    @(negedge clk);
    a_start = 1'b1;
    a_ready = 1'b1;
    @(posedge clk);
    #1;
    for (int n = 1; n <= NCYC; n++) begin
      a_ready = !(n >= st_lo && n <= st_hi);
      a_start = (n == restart_cyc);
      @(negedge clk);
      cv[n] = a_out_valid;
      cd[n] = a_done;
      crd[n] = a_rd_en;
      cce[n] = a_conv_en;
      cb[n] = a_busy;
      crdy[n] = a_ready;
      crow[n] = a_out_row;
      ccol[n] = a_out_col;
      c_sc_end = a_stall_cnt;
      @(posedge clk);
      #1;
    end
    a_start = 1'b0;
    a_ready = 1'b1;
  endtask

  task automatic verify_a(input string tag, input int vc[10], input int vr[10],
                          input int vl[10], input int rd_a, input int rd_b,
                          input int rd_c, input int rd_d, input int done_cyc,
                          input int exp_hs, input int exp_sc);
    int hs;
    hs = 0;
    for (int n = 1; n <= NCYC; n++) begin
      logic ev, erd, ed, eb;
      int er, ec;
      ev = 1'b0; er = 0; ec = 0;
      for (int i = 0; i < 10; i++)
        if (vc[i] == n) begin ev = 1'b1; er = vr[i]; ec = vl[i]; end
      erd = (n >= rd_a && n <= rd_b) || (n >= rd_c && n <= rd_d);
      ed = (n == done_cyc);
      eb = (n < done_cyc);
      total++;
      if (cv[n] !== ev) begin
        bad++;
        $display("FAIL %s out_valid cyc%0d: got %b want %b", tag, n, cv[n], ev);
      end
      if (ev) begin
        total++;
        if (crow[n] !== 2'(er) || ccol[n] !== 3'(ec)) begin
          bad++;
          $display("FAIL %s coord cyc%0d: got (%0d,%0d) want (%0d,%0d)",
                   tag, n, crow[n], ccol[n], er, ec);
        end
      end
      total++;
      if (crd[n] !== erd) begin
        bad++;
        $display("FAIL %s rd_en cyc%0d: got %b want %b", tag, n, crd[n], erd);
      end
      total++;
      if (cd[n] !== ed) begin
        bad++;
        $display("FAIL %s done cyc%0d: got %b want %b", tag, n, cd[n], ed);
      end
      total++;
      if (cb[n] !== eb) begin
        bad++;
        $display("FAIL %s busy cyc%0d: got %b want %b", tag, n, cb[n], eb);
      end
      if (cv[n] === 1'b1 && crdy[n] === 1'b1) hs++;
    end
    total++;
    if (hs != exp_hs) begin
      bad++;
      $display("FAIL %s handshakes: got %0d want %0d", tag, hs, exp_hs);
    end
    total++;
    if (c_sc_end !== 16'(exp_sc)) begin
      bad++;
      $display("FAIL %s stall_cnt: got %0d want %0d", tag, c_sc_end, exp_sc);
    end
  endtask

  task automatic test_reset();
    #3;
    total++;
    if ({a_busy, a_done, a_rd_en, a_rd_row, a_rd_col, a_conv_en, a_out_valid,
         a_out_row, a_out_col, a_stall_cnt} !== '0) begin
      bad++;
      $display("FAIL reset_a: got busy=%b rd_en=%b valid=%b sc=%0d want all 0",
               a_busy, a_rd_en, a_out_valid, a_stall_cnt);
    end
    total++;
    if ({b_busy, b_done, b_rd_en, b_rd_row, b_rd_col, b_conv_en, b_out_valid,
         b_out_row, b_out_col, b_stall_cnt} !== '0) begin
      bad++;
      $display("FAIL reset_b: got busy=%b valid=%b want all 0", b_busy, b_out_valid);
    end
    total++;
    if ({c_busy, c_done, c_rd_en, c_rd_row, c_rd_col, c_conv_en, c_out_valid,
         c_out_row, c_out_col, c_stall_cnt} !== '0) begin
      bad++;
      $display("FAIL reset_c: got busy=%b valid=%b want all 0", c_busy, c_out_valid);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    run_a(0, 0, 0);
    verify_a("basic", '{5, 6, 7, 10, 11, 12, 0, 0, 0, 0},
             '{0, 0, 0, 1, 1, 1, 0, 0, 0, 0},
             '{0, 1, 2, 0, 1, 2, 0, 0, 0, 0},
             1, 10, 0, 0, 13, 6, 0);
  endtask

  task automatic test_stall();
    run_a(5, 8, 0);
    verify_a("stall", '{5, 6, 7, 8, 9, 10, 11, 14, 15, 16},
             '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1},
             '{0, 0, 0, 0, 0, 1, 2, 0, 1, 2},
             1, 4, 9, 14, 17, 6, 4 * SC_ON);
    for (int n = 5; n <= 8; n++) begin
      total++;
      if (cce[n] !== 1'b0) begin
        bad++;
        $display("FAIL stall conv_en cyc%0d: got %b want 0", n, cce[n]);
      end
    end
  endtask

  task automatic test_restart_ignored();
    run_a(0, 0, 3);
    verify_a("restart", '{5, 6, 7, 10, 11, 12, 0, 0, 0, 0},
             '{0, 0, 0, 1, 1, 1, 0, 0, 0, 0},
             '{0, 1, 2, 0, 1, 2, 0, 0, 0, 0},
             1, 10, 0, 0, 13, 6, 0);
  endtask

  task automatic test_reset_mid_frame();
    @(negedge clk);
    a_start = 1'b1;
    a_ready = 1'b1;
    @(posedge clk);
    #1;
    a_start = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    total++;
    if (a_busy !== 1'b1) begin
      bad++;
      $display("FAIL midreset busy before: got %b want 1", a_busy);
    end
    rst = 1'b0;
    #1;
    total++;
    if ({a_busy, a_done, a_rd_en, a_rd_row, a_rd_col, a_conv_en, a_out_valid,
         a_out_row, a_out_col, a_stall_cnt} !== '0) begin
      bad++;
      $display("FAIL midreset outputs: got busy=%b rd_en=%b ce=%b valid=%b row=%0d col=%0d want all 0",
               a_busy, a_rd_en, a_conv_en, a_out_valid, a_rd_row, a_rd_col);
    end
    @(posedge clk);
    #1;
    total++;
    if (a_done !== 1'b0 || a_busy !== 1'b0) begin
      bad++;
      $display("FAIL midreset held: got done=%b busy=%b want 0 0", a_done, a_busy);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    run_a(0, 0, 0);
    verify_a("after_reset", '{5, 6, 7, 10, 11, 12, 0, 0, 0, 0},
             '{0, 0, 0, 1, 1, 1, 0, 0, 0, 0},
             '{0, 1, 2, 0, 1, 2, 0, 0, 0, 0},
             1, 10, 0, 0, 13, 6, 0);
  endtask

  task automatic test_small_3x3();
    @(negedge clk);
    b_start = 1'b1;
    @(posedge clk);
    #1;
    b_start = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      total++;
      if (b_out_valid !== (n == 5)) begin
        bad++;
        $display("FAIL small valid cyc%0d: got %b want %b", n, b_out_valid, n == 5);
      end
      if (n == 5) begin
        total++;
        if (b_out_row !== 2'd0 || b_out_col !== 2'd0) begin
          bad++;
          $display("FAIL small coord: got (%0d,%0d) want (0,0)", b_out_row, b_out_col);
        end
      end
      total++;
      if (b_done !== (n == 6)) begin
        bad++;
        $display("FAIL small done cyc%0d: got %b want %b", n, b_done, n == 6);
      end
      total++;
      if (b_rd_en !== (n <= 3)) begin
        bad++;
        $display("FAIL small rd_en cyc%0d: got %b want %b", n, b_rd_en, n <= 3);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_random_ready();
    int k, stalls, r, c, ref_sum, got_sum;
    logic seen_done;
    k = 0; stalls = 0; seen_done = 1'b0;
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 8; j++)
        img[i][j] = int'($urandom_range(0, 255));
    @(negedge clk);
    c_start = 1'b1;
    @(posedge clk);
    #1;
    c_start = 1'b0;
    for (int n = 1; n <= 2000 && !seen_done; n++) begin
      c_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (c_out_valid && !c_ready) stalls++;
      if (c_out_valid && c_ready) begin
        r = k / 6;
        c = k % 6;
        total++;
        if (c_out_row !== 3'(r) || c_out_col !== 3'(c)) begin
          bad++;
          $display("FAIL random coord #%0d: got (%0d,%0d) want (%0d,%0d)",
                   k, c_out_row, c_out_col, r, c);
        end
        ref_sum = 0;
        for (int di = 0; di < 3; di++)
          for (int dj = 0; dj < 3; dj++)
            ref_sum += img[r + di][c + dj];
        got_sum = w0[0] + w0[1] + w0[2] + w1[0] + w1[1] + w1[2] +
                  w2[0] + w2[1] + w2[2];
        total++;
        if (got_sum != ref_sum) begin
          bad++;
          $display("FAIL random conv #%0d: got %0d want %0d", k, got_sum, ref_sum);
        end
        k++;
      end
      if (c_done) seen_done = 1'b1;
      @(posedge clk);
      #1;
    end
    c_ready = 1'b1;
    total++;
    if (!seen_done) begin
      bad++;
      $display("FAIL random timeout: got no done want done within 2000 cycles");
    end
    total++;
    if (k != 24) begin
      bad++;
      $display("FAIL random count: got %0d want 24", k);
    end
    repeat (2) @(negedge clk);
    total++;
    if (c_stall_cnt !== 16'(stalls * SC_ON)) begin
      bad++;
      $display("FAIL random stall_cnt: got %0d want %0d", c_stall_cnt, stalls * SC_ON);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_restart_ignored();
    test_reset_mid_frame();
    test_small_3x3();
    test_random_ready();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
